// File: rtl/add_sub_serial.sv
// add_sub_serial: signed add/subtract computed one SLICE_WIDTH slice per clock,
// with start/done handshake, registered result, overflow detection and optional saturation.
module add_sub_serial #(
    parameter int         DATA_WIDTH  = 16,
    parameter int         SLICE_WIDTH = 4,
    parameter logic [3:0] FUNC_ADD    = 4'b0010,
    parameter logic [3:0] FUNC_SUB    = 4'b0110
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [3:0]            FuncCode,
    input  logic                  Saturate,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] C,
    output logic                  OverflowFlag
);
    localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int IW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam int MSB    = DATA_WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, c_q, c_d;
    logic                  sat_q, sat_d, ok_q, ok_d, of_q, of_d, done_q, done_d;
    logic [SLICE_WIDTH:0]  sum;
    logic                  ov, is_add, is_sub;

    assign is_add = FuncCode == FUNC_ADD;
    assign is_sub = FuncCode == FUNC_SUB;
    assign sum = {1'b0, a_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH]}
               + {1'b0, b_q[idx_q*SLICE_WIDTH +: SLICE_WIDTH]}
               + {{SLICE_WIDTH{1'b0}}, carry_q};
    // b_q already holds ~B for subtraction, so one same-sign test covers both modes
    assign ov = (a_q[MSB] == b_q[MSB]) && (r_q[MSB] != a_q[MSB]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        sat_d   = sat_q;
        ok_d    = ok_q;
        c_d     = c_q;
        of_d    = of_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                a_d     = A;
                b_d     = is_sub ? ~B : B;
                carry_d = is_sub;
                sat_d   = Saturate;
                ok_d    = is_add || is_sub;
                idx_d   = '0;
                r_d     = '0;
                state_d = (is_add || is_sub) ? RUN : FIN;
            end
            RUN: begin
                r_d[idx_q*SLICE_WIDTH +: SLICE_WIDTH] = sum[SLICE_WIDTH-1:0];
                carry_d = sum[SLICE_WIDTH];
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == IW'(NSLICE - 1)) ? FIN : RUN;
            end
            FIN: begin
                done_d  = 1'b1;
                of_d    = ok_q && ov;
                c_d     = !ok_q ? '0 :
                          (sat_q && ov) ? (a_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}}) :
                          r_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            sat_q   <= 1'b0;
            ok_q    <= 1'b0;
            c_q     <= '0;
            of_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            sat_q   <= sat_d;
            ok_q    <= ok_d;
            c_q     <= c_d;
            of_q    <= of_d;
            done_q  <= done_d;
        end
    end

    assign busy         = state_q != IDLE;
    assign done         = done_q;
    assign C            = c_q;
    assign OverflowFlag = of_q;
endmodule
